brush_plotter: RTL and testbench
================================

Name: brush_plotter

Overview:
- Downstream of the paint controller: takes the latched brush state (cursor position, colour, size, draw/erase mode) and converts one "stamp" request into a stream of single-pixel writes for the VGA adapter (160x120, 3-bit colour).
- Walks an NxN square, one pixel per clock, clips pixels that fall off screen, and reports busy/done to the controller.

Parameters:
- X_MAX, 160, screen width in pixels; pixels with x >= X_MAX are clipped
- Y_MAX, 120, screen height in pixels; pixels with y >= Y_MAX are clipped
- XW, 8, x coordinate width
- YW, 7, y coordinate width

Ports:
- Clock  in  1  system clock; all state updates on its rising edge
- Reset  in  1  synchronous, active-high reset
- go  in  1  stamp request; sampled only in IDLE
- x_in  in  XW  brush top-left x
- y_in  in  YW  brush top-left y
- colour_in  in  3  brush colour
- size  in  2  brush side: 00=1, 01=2, 10=4, 11=8 pixels
- erase  in  1  1 = paint black (3'b000) regardless of colour_in
- x  out  XW  pixel x to VGA adapter
- y  out  YW  pixel y to VGA adapter
- colour  out  3  pixel colour to VGA adapter
- plot  out  1  write-enable to VGA adapter, valid with x/y/colour
- busy  out  1  high from the cycle after go is accepted through the last DRAW cycle
- done  out  1  one-cycle pulse after the last pixel slot

Behaviour:
- One clock, Clock. Reset is synchronous and active-high, named Reset.
- Reset values: x=0, y=0, colour=0, plot=0, busy=0, done=0; FSM=IDLE; dx=dy=0.
- Reset wins over every other input. If Reset is asserted mid-stamp, the block returns to reset values on that edge, no further plot is issued, and done is not pulsed.
- FSM states: IDLE, DRAW, DONE.
- IDLE:
  - When go=1, latch x_in, y_in, size, and colour (colour = erase ? 0 : colour_in).
  - Clear dx and dy, then go to DRAW.
  - Inputs are not sampled again until the next IDLE.
- DRAW:
  - Each cycle presents one pixel slot: x = xb+dx, y = yb+dy, registered.
  - The first slot appears on outputs the cycle after go is sampled.
  - dx increments fastest. When dx=N-1, dx wraps to 0 and dy increments.
  - After slot (N-1,N-1), go to DONE.
  - Exactly N*N DRAW cycles, for N = 1, 2, 4 or 8.
- Clipping:
  - Sums are computed at XW+1 / YW+1 bits so that no wrap occurs.
  - plot=1 only if xb+dx < X_MAX and yb+dy < Y_MAX.
  - A clipped slot still consumes its cycle. During a clipped slot x/y hold the truncated sum and plot=0.
- DONE: done=1 and busy=0 for one cycle, plot=0, then return to IDLE. go is ignored in DONE.
- go while busy or in DONE is ignored; it is not queued.
- Back-to-back stamps: go held high continuously restarts a stamp every N*N+2 cycles.
- Outside DRAW, plot=0 and x/y/colour hold their last values.

Optional Feature:
- Macro: BRUSH_ROUND_EN
- Defined:
  - N=4: the 4 corner pixels are suppressed (plot=0).
  - N=8: a pixel is suppressed when min(dx,7-dx)+min(dy,7-dy) < 2, which is 3 pixels per corner (12 total).
  - N=1 and N=2 are unchanged.
  - Cycle count and done timing are identical to the undefined case.
- Undefined: every in-screen slot plots, giving a full square.

Test Plan:
- Reset, then go with x_in=10, y_in=20, size=00, colour_in=3'b101 -> one plot at (10,20) colour 101 the cycle after go; done pulses the following cycle; busy high for exactly 1 cycle.
- size=10, x_in=0, y_in=0, colour_in=3'b010 -> 16 consecutive plots in order (0,0),(1,0),(2,0),(3,0),(0,1)...(3,3); done the cycle after (3,3).
- size=11, x_in=156, y_in=117, erase=1 -> 64 DRAW cycles; plot=1 only for x in 156..159 and y in 117..119 (12 pixels), colour=000; done after cycle 64.
- size=11 stamp, then go pulsed mid-stamp, then Reset asserted at DRAW cycle 20 -> the mid-stamp go is ignored; after reset, plot, busy and done are 0 on the next edge, no done pulse, and a subsequent go starts cleanly at dx=dy=0.
- go held high continuously, size=01 -> a stamp every 6 cycles (1 latch, 4 DRAW, 1 DONE); inputs changed during DRAW do not affect that stamp's x/y/colour.
- With BRUSH_ROUND_EN defined, size=11 at (50,50) -> 52 plots, with corners (50,50),(51,50),(50,51) absent; with size=10, 12 plots; done timing matches the undefined build.

Source files
------------

// File: rtl/brush_plotter_if.sv
`default_nettype none
// ============================================================================
// Module : brush_plotter_if
// Brief  : Stamp request / pixel-write bundle between the paint controller
//          (master) and the brush plotter (slave).
// Rev    : 1.0  initial release
// ============================================================================
interface brush_plotter_if #(
    parameter int XW = 8,
    parameter int YW = 7
);
    logic          go;
    logic [XW-1:0] x_in;
    logic [YW-1:0] y_in;
    logic [2:0]    colour_in;
    logic [1:0]    size;
    logic          erase;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [2:0]    colour;
    logic          plot;
    logic          busy;
    logic          done;

    modport master (
        output go, x_in, y_in, colour_in, size, erase,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  go, x_in, y_in, colour_in, size, erase,
        output x, y, colour, plot, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/brush_plotter.sv
`default_nettype none
// ============================================================================
// Module : brush_plotter
// Brief  : Expands one brush stamp into an NxN stream of clipped pixel writes.
//          Optional macro BRUSH_ROUND_EN rounds the corners of 4x4 and 8x8.
// Rev    : 1.0  initial release
// ============================================================================
module brush_plotter #(
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120,
    parameter int XW    = 8,
    parameter int YW    = 7
) (
    input wire              Clock,
    input wire              Reset,
    brush_plotter_if.slave  bus
);
    localparam logic [XW:0] c_X_MAX = (XW+1)'(X_MAX);
    localparam logic [YW:0] c_Y_MAX = (YW+1)'(Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [XW-1:0] r_xb;
    logic [YW-1:0] r_yb;
    logic [1:0]    r_size;
    logic [2:0]    r_dx;
    logic [2:0]    r_dy;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [2:0]    r_colour;
    logic          r_plot;
    logic          r_busy;
    logic          r_done;

    logic          w_idle;
    logic [1:0]    w_size;
    logic [2:0]    w_nm1;
    logic          w_last_x;
    logic          w_last;
    logic [2:0]    w_ndx;
    logic [2:0]    w_ndy;
    logic [XW-1:0] w_bx;
    logic [YW-1:0] w_by;
    logic [XW:0]   w_sx;
    logic [YW:0]   w_sy;
    logic          w_keep;
    logic          w_plot_next;

    // The slot being computed is the first one when leaving IDLE, else the successor of (r_dx,r_dy)
    assign w_idle   = (r_state == S_IDLE);
    assign w_size   = w_idle ? bus.size : r_size;
    assign w_nm1    = 3'((4'd1 << w_size) - 4'd1);
    assign w_last_x = (r_dx == w_nm1);
    assign w_last   = w_last_x && (r_dy == w_nm1);
    assign w_ndx    = (w_idle || w_last_x) ? 3'd0 : r_dx + 3'd1;
    assign w_ndy    = w_idle ? 3'd0 : (w_last_x ? r_dy + 3'd1 : r_dy);
    assign w_bx     = w_idle ? bus.x_in : r_xb;
    assign w_by     = w_idle ? bus.y_in : r_yb;
    assign w_sx     = {1'b0, w_bx} + {{(XW-2){1'b0}}, w_ndx};
    assign w_sy     = {1'b0, w_by} + {{(YW-2){1'b0}}, w_ndy};

`ifdef BRUSH_ROUND_EN
    logic [2:0] w_ex;
    logic [2:0] w_ey;
    logic [2:0] w_thr;
    // Distance to the nearest edge on each axis; corner cells lie below a size-dependent threshold
    assign w_ex   = (w_ndx < 3'(w_nm1 - w_ndx)) ? w_ndx : 3'(w_nm1 - w_ndx);
    assign w_ey   = (w_ndy < 3'(w_nm1 - w_ndy)) ? w_ndy : 3'(w_nm1 - w_ndy);
    assign w_thr  = (w_size == 2'd3) ? 3'd2 : ((w_size == 2'd2) ? 3'd1 : 3'd0);
    assign w_keep = ({1'b0, w_ex} + {1'b0, w_ey}) >= {1'b0, w_thr};
`else
    assign w_keep = 1'b1;
`endif

    assign w_plot_next = (w_sx < c_X_MAX) && (w_sy < c_Y_MAX) && w_keep;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_xb     <= '0;
            r_yb     <= '0;
            r_size   <= 2'd0;
            r_dx     <= 3'd0;
            r_dy     <= 3'd0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= 3'd0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_plot <= 1'b0;
                    r_done <= 1'b0;
                    if (bus.go) begin
                        r_xb     <= bus.x_in;
                        r_yb     <= bus.y_in;
                        r_size   <= bus.size;
                        r_colour <= bus.erase ? 3'd0 : bus.colour_in;
                        r_dx     <= 3'd0;
                        r_dy     <= 3'd0;
                        r_x      <= w_sx[XW-1:0];
                        r_y      <= w_sy[YW-1:0];
                        r_plot   <= w_plot_next;
                        r_busy   <= 1'b1;
                        r_state  <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (w_last) begin
                        r_plot  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_dx   <= w_ndx;
                        r_dy   <= w_ndy;
                        r_x    <= w_sx[XW-1:0];
                        r_y    <= w_sy[YW-1:0];
                        r_plot <= w_plot_next;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.x      = r_x;
    assign bus.y      = r_y;
    assign bus.colour = r_colour;
    assign bus.plot   = r_plot;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule
`default_nettype wire

// File: tb/tb_brush_plotter.sv
`default_nettype none
// ============================================================================
// Module : tb_brush_plotter
// Brief  : Self-checking bench for brush_plotter (table vectors, corner
//          sequences and random stamps against a pixel-list reference model).
// Rev    : 1.0  initial release
// ============================================================================
module tb_brush_plotter;
    localparam int X_MAX = 160;
    localparam int Y_MAX = 120;
`ifdef BRUSH_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    brush_plotter_if #(.XW(8), .YW(7)) bus ();

    brush_plotter #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .XW(8), .YW(7)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic [1:0] s;
        bit         e;
        int         plots;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Rounded brush: drop the cells nearest each corner by Manhattan distance
    function automatic bit round_keep(input int n, input int dx, input int dy);
        int ex, ey;
        ex = (dx < n-1-dx) ? dx : n-1-dx;
        ey = (dy < n-1-dy) ? dy : n-1-dy;
        if (!RND) return 1'b1;
        if (n == 4) return !(ex == 0 && ey == 0);
        if (n == 8) return (ex + ey) >= 2;
        return 1'b1;
    endfunction

    task automatic check_slot(input int xb, input int yb, input int col, input int sz,
                              input bit er, input int dx, input int dy, output bit p);
        int n;
        bit ep;
        n  = 1 << sz;
        ep = (xb+dx < X_MAX) && (yb+dy < Y_MAX) && round_keep(n, dx, dy);
        chk("slot_x",      int'(bus.x),      (xb+dx) % 256);
        chk("slot_y",      int'(bus.y),      (yb+dy) % 128);
        chk("slot_plot",   int'(bus.plot),   int'(ep));
        chk("slot_colour", int'(bus.colour), er ? 0 : col);
        chk("slot_busy",   int'(bus.busy),   1);
        chk("slot_done",   int'(bus.done),   0);
        p = bus.plot;
    endtask

    task automatic drive(input int xv, input int yv, input int c, input int s, input bit e, input bit g);
        bus.x_in      = 8'(xv);
        bus.y_in      = 7'(yv);
        bus.colour_in = 3'(c);
        bus.size      = 2'(s);
        bus.erase     = e;
        bus.go        = g;
    endtask

    // Called at a negedge in IDLE with go already driven; returns at the negedge of the DONE cycle
    task automatic expect_stamp(input int xb, input int yb, input int col, input int sz,
                                input bit er, input int exp_plots, input bit drop_go);
        int n;
        int plots;
        bit p;
        n     = 1 << sz;
        plots = 0;
        @(posedge Clock);
        @(negedge Clock);
        if (drop_go) bus.go = 1'b0;
        for (int dy = 0; dy < n; dy++) begin
            for (int dx = 0; dx < n; dx++) begin
                check_slot(xb, yb, col, sz, er, dx, dy, p);
                plots += int'(p);
                @(negedge Clock);
            end
        end
        chk("done_pulse", int'(bus.done), 1);
        chk("done_busy",  int'(bus.busy), 0);
        chk("done_plot",  int'(bus.plot), 0);
        if (exp_plots >= 0) chk("plot_count", plots, exp_plots);
    endtask

    vec_t tbl [7];

    initial begin
        bit saw_done;
        bit saw_plot;
        bit p;
        int rx, ry, rc, rs;
        bit re;

        tbl[0] = '{x: 8'd10,  y: 7'd20,  c: 3'd5, s: 2'd0, e: 1'b0, plots: 1};
        tbl[1] = '{x: 8'd0,   y: 7'd0,   c: 3'd2, s: 2'd2, e: 1'b0, plots: RND ? 12 : 16};
        tbl[2] = '{x: 8'd156, y: 7'd117, c: 3'd6, s: 2'd3, e: 1'b1, plots: RND ? 9 : 12};
        tbl[3] = '{x: 8'd50,  y: 7'd50,  c: 3'd3, s: 2'd3, e: 1'b0, plots: RND ? 52 : 64};
        tbl[4] = '{x: 8'd159, y: 7'd119, c: 3'd7, s: 2'd1, e: 1'b0, plots: 1};
        tbl[5] = '{x: 8'd200, y: 7'd10,  c: 3'd4, s: 2'd2, e: 1'b0, plots: 0};
        tbl[6] = '{x: 8'd157, y: 7'd118, c: 3'd1, s: 2'd2, e: 1'b0, plots: RND ? 5 : 6};

        drive(0, 0, 0, 0, 1'b0, 1'b0);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        chk("rst_x",      int'(bus.x),      0);
        chk("rst_y",      int'(bus.y),      0);
        chk("rst_colour", int'(bus.colour), 0);
        chk("rst_plot",   int'(bus.plot),   0);
        chk("rst_busy",   int'(bus.busy),   0);
        chk("rst_done",   int'(bus.done),   0);
        Reset = 1'b0;
        @(negedge Clock);

        foreach (tbl[i]) begin
            drive(tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].s, tbl[i].e, 1'b1);
            expect_stamp(tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].s, tbl[i].e, tbl[i].plots, 1'b1);
            @(negedge Clock);
            chk("idle_done", int'(bus.done), 0);
            chk("idle_busy", int'(bus.busy), 0);
        end

        // Back-to-back stamps with go held; inputs swapped during the first stamp's DRAW
        drive(40, 60, 5, 1, 1'b0, 1'b1);
        fork
            begin
                @(negedge Clock);
                @(negedge Clock);
                drive(90, 30, 2, 1, 1'b0, 1'b1);
            end
        join_none
        expect_stamp(40, 60, 5, 1, 1'b0, 4, 1'b0);
        @(negedge Clock);
        chk("b2b_gap_plot", int'(bus.plot), 0);
        chk("b2b_gap_busy", int'(bus.busy), 0);
        expect_stamp(90, 30, 2, 1, 1'b0, 4, 1'b1);
        @(negedge Clock);

        // Mid-stamp go is ignored, then reset during DRAW cycle 20 aborts the stamp
        drive(30, 40, 6, 3, 1'b0, 1'b1);
        @(posedge Clock);
        @(negedge Clock);
        bus.go = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check_slot(30, 40, 6, 3, 1'b0, k % 8, k / 8, p);
            if (k == 9)  drive(100, 5, 1, 0, 1'b0, 1'b1);
            if (k == 10) bus.go = 1'b0;
            if (k == 19) Reset = 1'b1;
            @(negedge Clock);
        end
        chk("abort_plot",   int'(bus.plot),   0);
        chk("abort_busy",   int'(bus.busy),   0);
        chk("abort_done",   int'(bus.done),   0);
        chk("abort_x",      int'(bus.x),      0);
        chk("abort_colour", int'(bus.colour), 0);
        Reset    = 1'b0;
        saw_done = 1'b0;
        saw_plot = 1'b0;
        repeat (80) begin
            @(negedge Clock);
            saw_done |= bus.done;
            saw_plot |= bus.plot;
        end
        chk("abort_no_done", int'(saw_done), 0);
        chk("abort_no_plot", int'(saw_plot), 0);
        drive(12, 34, 3, 2, 1'b0, 1'b1);
        expect_stamp(12, 34, 3, 2, 1'b0, RND ? 12 : 16, 1'b1);
        @(negedge Clock);

        // Random stamps, including x/y beyond the screen to exercise wide sums
        repeat (24) begin
            rx = int'($urandom_range(0, 255));
            ry = int'($urandom_range(0, 127));
            rc = int'($urandom_range(0, 7));
            rs = int'($urandom_range(0, 3));
            re = 1'($urandom_range(0, 1));
            drive(rx, ry, rc, rs, re, 1'b1);
            expect_stamp(rx, ry, rc, rs, re, -1, 1'b1);
            @(negedge Clock);
            chk("rand_idle_done", int'(bus.done), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
